// File: rtl/qam_demapper_pkg.sv
// Shared definitions for the demapper FIFO read arbiter: FSM encoding,
// default symbol width and consumer IDs.
package qam_demapper_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DRAIN = 2'd2
    } arb_state_t;

    localparam int DATA_W_DEF = 4;

    localparam logic ID_MAIN  = 1'b0;
    localparam logic ID_DEBUG = 1'b1;

    function automatic logic [1:0] id_onehot(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/qam_rr_pick2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the
// consumer that did not own the previous grant.
module qam_rr_pick2
    import qam_demapper_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_gnt,
    output logic       winner,
    output logic       valid
);

    always_comb begin
        valid  = |req;
        winner = ID_MAIN;
        if (req == 2'b11) begin
            winner = ~last_gnt;
        end else if (req[1]) begin
            winner = ID_DEBUG;
        end
    end

endmodule

// File: rtl/qam_fifo_read_arbiter.sv
// Shares the demapper output FIFO read port between the main host and the
// debug tap in round-robin bursts; returns popped words tagged by owner.
module qam_fifo_read_arbiter
    import qam_demapper_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int BURST_LEN = 16,
    parameter int CNT_W     = 16
) (
    input  logic              dclk,
    input  logic              reset,
    input  logic              enable,
    input  logic [1:0]        req,
    output logic [1:0]        gnt,
    input  logic              rdempty,
    output logic              rdreq,
    input  logic [DATA_W-1:0] fifo_q,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              dout_id,
    output logic [1:0]        burst_done,
    output logic [CNT_W-1:0]  served0,
    output logic [CNT_W-1:0]  served1
);

    localparam logic [7:0] BEAT_MAX  = 8'(BURST_LEN);
    localparam logic [7:0] BEAT_LAST = 8'(BURST_LEN - 1);

    arb_state_t state;
    logic       owner;
    logic       last_gnt;
    logic [7:0] beat_cnt;
    logic       pop_d;
    logic       pop_id;
    logic       pick_id;
    logic       pick_valid;

    qam_rr_pick2 u_pick (
        .req      (req),
        .last_gnt (last_gnt),
        .winner   (pick_id),
        .valid    (pick_valid)
    );

    assign rdreq = (state == ST_BURST) && enable && req[owner] && !rdempty
                   && (beat_cnt < BEAT_MAX);

    always_ff @(posedge dclk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            gnt        <= 2'b00;
            owner      <= ID_MAIN;
            last_gnt   <= ID_DEBUG;
            beat_cnt   <= 8'd0;
            burst_done <= 2'b00;
        end else begin
            burst_done <= 2'b00;
            case (state)
                ST_IDLE: begin
                    if (enable && pick_valid) begin
                        gnt      <= id_onehot(pick_id);
                        owner    <= pick_id;
                        beat_cnt <= 8'd0;
                        state    <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    if (rdreq) begin
                        beat_cnt <= beat_cnt + 8'd1;
                    end
                    // any cycle without a pop ends the burst, as does the last allowed pop
                    if (!rdreq || (beat_cnt == BEAT_LAST)) begin
                        state      <= ST_DRAIN;
                        burst_done <= id_onehot(owner);
                    end
                end
                ST_DRAIN: begin
                    gnt      <= 2'b00;
                    last_gnt <= owner;
                    state    <= ST_IDLE;
                end
                default: begin
                    gnt   <= 2'b00;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // FIFO data lags rdreq by one cycle, so the owner tag rides along in pop_id
    always_ff @(posedge dclk or posedge reset) begin
        if (reset) begin
            pop_d      <= 1'b0;
            pop_id     <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
            dout_id    <= 1'b0;
            served0    <= '0;
            served1    <= '0;
        end else begin
            pop_d      <= rdreq;
            pop_id     <= owner;
            dout_valid <= pop_d;
            if (pop_d) begin
                dout    <= fifo_q;
                dout_id <= pop_id;
            end
            if (dout_valid) begin
                if (dout_id) begin
                    served1 <= served1 + CNT_W'(1);
                end else begin
                    served0 <= served0 + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_qam_fifo_read_arbiter.sv
// Bench for qam_fifo_read_arbiter: directed scenarios against a burst-level
// expectation model, plus a CNT_W=4 instance to exercise counter wrap.
module tb_qam_fifo_read_arbiter;

    localparam int DW = 4;
    localparam int BL = 16;

    logic          dclk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic [1:0]    req = 2'b00;
    logic          rdempty = 1'b1;
    logic [DW-1:0] fifo_q = '0;

    logic [1:0]    gnt, burst_done, gnt_n, burst_done_n;
    logic          rdreq, dout_valid, dout_id, rdreq_n, dout_valid_n, dout_id_n;
    logic [DW-1:0] dout, dout_n;
    logic [15:0]   served0, served1;
    logic [3:0]    served0_n, served1_n;

    qam_fifo_read_arbiter #(.DATA_W(DW), .BURST_LEN(BL), .CNT_W(16)) dut (
        .dclk(dclk), .reset(reset), .enable(enable), .req(req), .gnt(gnt),
        .rdempty(rdempty), .rdreq(rdreq), .fifo_q(fifo_q), .dout(dout),
        .dout_valid(dout_valid), .dout_id(dout_id), .burst_done(burst_done),
        .served0(served0), .served1(served1)
    );

    qam_fifo_read_arbiter #(.DATA_W(DW), .BURST_LEN(BL), .CNT_W(4)) dut_n (
        .dclk(dclk), .reset(reset), .enable(enable), .req(req), .gnt(gnt_n),
        .rdempty(rdempty), .rdreq(rdreq_n), .fifo_q(fifo_q), .dout(dout_n),
        .dout_valid(dout_valid_n), .dout_id(dout_id_n), .burst_done(burst_done_n),
        .served0(served0_n), .served1(served1_n)
    );

    always #5 dclk = ~dclk;

    typedef struct {
        int            due;
        logic [DW-1:0] data;
        logic          id;
    } exp_t;

    int            n_vec = 0;
    int            n_err = 0;
    logic [DW-1:0] fifo[$];
    exp_t          pipe[$];
    int            cyc = 0;
    int            m_owner = -1;
    int            m_last = 1;
    int            m_beats = 0;
    bit            m_ended = 0;
    int            m_served[2];
    int            obs_done[2];
    int            obs_grants[$];
    int            obs_pops[$];
    int            cur_pops, run_len, max_run, obs_valid, obs_id1;
    logic [1:0]    prev_gnt = 2'b00;

    function automatic logic [1:0] oh(input int id);
        return (id != 0) ? 2'b10 : 2'b01;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_stats();
        obs_done = '{0, 0};
        obs_grants.delete();
        obs_pops.delete();
        cur_pops = 0; run_len = 0; max_run = 0; obs_valid = 0; obs_id1 = 0;
    endtask

    task automatic model_reset();
        pipe.delete();
        m_owner = -1; m_last = 1; m_beats = 0; m_ended = 0;
        m_served = '{0, 0};
        prev_gnt = 2'b00; cur_pops = 0; run_len = 0;
    endtask

    // Expected outputs for this cycle from the burst rules, then advance the model.
    task automatic model_cycle();
        logic [1:0] e_gnt, e_done;
        logic       e_rd;
        bit         e_valid;
        e_gnt  = (m_owner < 0) ? 2'b00 : oh(m_owner);
        e_rd   = 1'b0;
        if (m_owner >= 0 && !m_ended)
            e_rd = enable && req[m_owner] && !rdempty && (m_beats < BL);
        e_done  = (m_owner >= 0 && m_ended) ? oh(m_owner) : 2'b00;
        e_valid = (pipe.size() > 0) && (pipe[0].due == cyc);

        chk("gnt", gnt, e_gnt);
        chk("gnt_n", gnt_n, e_gnt);
        chk("rdreq", rdreq, e_rd);
        chk("rdreq_n", rdreq_n, e_rd);
        chk("burst_done", burst_done, e_done);
        chk("burst_done_n", burst_done_n, e_done);
        chk("dout_valid", dout_valid, e_valid);
        chk("dout_valid_n", dout_valid_n, e_valid);
        if (e_valid) begin
            chk("dout", dout, pipe[0].data);
            chk("dout_id", dout_id, pipe[0].id);
            chk("dout_n", dout_n, pipe[0].data);
            chk("dout_id_n", dout_id_n, pipe[0].id);
        end
        chk("served0", served0, m_served[0] % 65536);
        chk("served1", served1, m_served[1] % 65536);
        chk("served0_n", served0_n, m_served[0] % 16);
        chk("served1_n", served1_n, m_served[1] % 16);

        if (burst_done[0]) obs_done[0]++;
        if (burst_done[1]) obs_done[1]++;
        if (dout_valid) begin
            obs_valid++;
            if (dout_id) obs_id1++;
        end
        if (gnt != 2'b00 && prev_gnt == 2'b00) obs_grants.push_back(int'(gnt[1]));
        if (rdreq) begin
            cur_pops++;
            run_len++;
            if (run_len > max_run) max_run = run_len;
        end else begin
            run_len = 0;
        end
        if (gnt == 2'b00 && prev_gnt != 2'b00) begin
            obs_pops.push_back(cur_pops);
            cur_pops = 0;
        end
        prev_gnt = gnt;

        if (e_valid) begin
            m_served[pipe[0].id]++;
            void'(pipe.pop_front());
        end
        if (m_owner < 0) begin
            if (enable && req != 2'b00) begin
                if (req == 2'b11) m_owner = 1 - m_last;
                else              m_owner = req[1] ? 1 : 0;
                m_beats = 0;
                m_ended = 0;
            end
        end else if (m_ended) begin
            m_last  = m_owner;
            m_owner = -1;
        end else if (e_rd) begin
            pipe.push_back('{due: cyc + 2, data: fifo[0], id: m_owner[0]});
            m_beats++;
            if (m_beats == BL) m_ended = 1;
        end else begin
            m_ended = 1;
        end
        cyc++;
    endtask

    // One clock: check at the falling edge, then play the FIFO just after the rising edge.
    task automatic tick();
        logic pop;
        @(negedge dclk);
        if (reset) model_reset();
        else       model_cycle();
        pop = rdreq && !reset;
        @(posedge dclk);
        #1;
        if (pop && fifo.size() > 0) fifo_q = fifo.pop_front();
        rdempty = (fifo.size() == 0);
    endtask

    task automatic load(input int n, input int base);
        for (int i = 0; i < n; i++) fifo.push_back(DW'(base + i));
        rdempty = (fifo.size() == 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        clear_stats();
    endtask

    task automatic run_until_empty(input string nm, input int budget);
        int k = 0;
        while (fifo.size() != 0 && k < budget) begin
            tick();
            k++;
        end
        chk({nm, "_left_in_fifo"}, fifo.size(), 0);
        tick();
        req = 2'b00;
        repeat (6) tick();
    endtask

    task automatic chk_pops(input string nm, input int n, input int a, input int b,
                            input int c, input int d);
        int e[4];
        e = '{a, b, c, d};
        chk({nm, "_burst_count"}, obs_pops.size(), n);
        for (int i = 0; i < n && i < obs_pops.size(); i++)
            chk({nm, "_burst_pops"}, obs_pops[i], e[i]);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        m_served = '{0, 0};
        clear_stats();
        tick();
        tick();
        chk("rst_gnt", gnt, 0);
        chk("rst_rdreq", rdreq, 0);
        chk("rst_dout", dout, 0);
        chk("rst_dout_valid", dout_valid, 0);
        chk("rst_burst_done", burst_done, 0);
        chk("rst_served0", served0, 0);
        reset = 1'b0;
        enable = 1'b1;
        clear_stats();
        tick();

        // 1: 40 words, main host only
        load(40, 3);
        req = 2'b01;
        run_until_empty("t1", 200);
        chk_pops("t1", 3, 16, 16, 8, 0);
        chk("t1_max_rdreq_run", max_run, 16);
        chk("t1_served0", served0, 40);
        chk("t1_done0", obs_done[0], 3);
        chk("t1_done1", obs_done[1], 0);

        // 2: both consumers, 64 words
        do_reset();
        load(64, 7);
        req = 2'b11;
        run_until_empty("t2", 300);
        chk_pops("t2", 4, 16, 16, 16, 16);
        chk("t2_grants", obs_grants.size(), 4);
        if (obs_grants.size() == 4) begin
            chk("t2_grant0", obs_grants[0], 0);
            chk("t2_grant1", obs_grants[1], 1);
            chk("t2_grant2", obs_grants[2], 0);
            chk("t2_grant3", obs_grants[3], 1);
        end
        chk("t2_served0", served0, 32);
        chk("t2_served1", served1, 32);

        // 3: debug tap only, FIFO runs dry after 5 pops
        do_reset();
        load(5, 9);
        req = 2'b10;
        run_until_empty("t3", 50);
        chk_pops("t3", 1, 5, 0, 0, 0);
        chk("t3_done1", obs_done[1], 1);
        chk("t3_valid_count", obs_valid, 5);
        chk("t3_id1_count", obs_id1, 5);
        chk("t3_served1", served1, 5);

        // 4: enable dropped after 3 pops
        do_reset();
        load(10, 1);
        req = 2'b01;
        for (int k = 0; k < 20 && fifo.size() != 7; k++) tick();
        chk("t4_pops_before_drop", fifo.size(), 7);
        enable = 1'b0;
        #2;
        chk("t4_rdreq_off", rdreq, 0);
        tick();
        chk("t4_gnt_drain", gnt, 2'b01);
        tick();
        chk("t4_gnt_idle", gnt, 0);
        repeat (4) tick();
        chk("t4_no_regrant", gnt, 0);
        chk("t4_served0", served0, 3);
        chk("t4_valid_count", obs_valid, 3);
        chk("t4_fifo_left", fifo.size(), 7);
        req = 2'b00;
        enable = 1'b1;
        fifo.delete();
        rdempty = 1'b1;
        tick();

        // 5: asynchronous reset mid-burst
        do_reset();
        load(20, 5);
        req = 2'b11;
        for (int k = 0; k < 20 && fifo.size() != 16; k++) tick();
        chk("t5_pops_before_reset", fifo.size(), 16);
        #2;
        reset = 1'b1;
        #1;
        chk("t5_gnt_async", gnt, 0);
        chk("t5_rdreq_async", rdreq, 0);
        chk("t5_dout_valid_async", dout_valid, 0);
        chk("t5_served0_async", served0, 0);
        chk("t5_served1_async", served1, 0);
        tick();
        reset = 1'b0;
        clear_stats();
        run_until_empty("t5", 100);
        chk("t5_regrant_count", obs_grants.size(), 1);
        if (obs_grants.size() > 0) chk("t5_regrant_to0", obs_grants[0], 0);
        chk_pops("t5", 1, 16, 0, 0, 0);
        chk("t5_served0", served0, 16);
        chk("t5_served1", served1, 0);

        // 6: narrow counter wraps 15 -> 0
        do_reset();
        load(20, 11);
        req = 2'b01;
        run_until_empty("t6", 100);
        chk_pops("t6", 2, 16, 4, 0, 0);
        chk("t6_served0_wide", served0, 20);
        chk("t6_served0_wrap", served0_n, 4);
        chk("t6_served1_wrap", served1_n, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
